// File: rtl/div_simple.sv
// Sequential restoring divider: 2*WIDTH-bit dividend by WIDTH-bit divisor, one quotient
// bit per clock, with the same istart/ovalid/oready handshake as the multiplier.
module div_simple #(
    parameter int unsigned WIDTH = 5
) (
    input  logic               iclk,
    input  logic               irst_n,
    input  logic [2*WIDTH-1:0] ia,
    input  logic [WIDTH-1:0]   ib,
    input  logic               istart,
    output logic [2*WIDTH-1:0] oquot,
    output logic [WIDTH-1:0]   orem,
    output logic               odiv0,
    output logic               ovalid,
    output logic               oready
);

    localparam int unsigned CntW = $clog2(2 * WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e             state_q, state_d;
    // Dividend shifts out MSB-first while quotient bits shift in at the LSB.
    logic [2*WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic [WIDTH:0]     rem_q, rem_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               div0_q, div0_d;
    logic [2*WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0]   orem_q, orem_d;
    logic               odiv0_q, odiv0_d;
    logic               valid_q, valid_d;

    logic [WIDTH:0]     rem_shift;
    logic [WIDTH:0]     rem_sub;
    logic               rem_ge;

    assign rem_shift = {rem_q[WIDTH-1:0], dvd_q[2*WIDTH-1]};
    assign rem_sub   = rem_shift - {1'b0, dvs_q};
    assign rem_ge    = (rem_shift >= {1'b0, dvs_q});

    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        div0_d  = div0_q;
        quot_d  = quot_q;
        orem_d  = orem_q;
        odiv0_d = odiv0_q;
        valid_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (istart) begin
                    state_d = StRun;
                    dvs_d   = ib;
                    rem_d   = '0;
                    if (ib != '0) begin
                        dvd_d  = ia;
                        div0_d = 1'b0;
                        cnt_d  = CntW'(2 * WIDTH);
                    end else begin
                        // Zero divisor: preload the result and skip all steps, so the
                        // result appears one edge later through the normal DONE entry.
                        dvd_d  = '1;
                        div0_d = 1'b1;
                        cnt_d  = '0;
                    end
                end
            end
            StRun: begin
                if (cnt_q != '0) begin
                    rem_d = rem_ge ? rem_sub : rem_shift;
                    dvd_d = {dvd_q[2*WIDTH-2:0], rem_ge};
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = StDone;
                    quot_d  = dvd_q;
                    orem_d  = rem_q[WIDTH-1:0];
                    odiv0_d = div0_q;
                    valid_d = 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            state_q <= StIdle;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            div0_q  <= 1'b0;
            quot_q  <= '0;
            orem_q  <= '0;
            odiv0_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            div0_q  <= div0_d;
            quot_q  <= quot_d;
            orem_q  <= orem_d;
            odiv0_q <= odiv0_d;
            valid_q <= valid_d;
        end
    end

    assign oquot  = quot_q;
    assign orem   = orem_q;
    assign odiv0  = odiv0_q;
    assign ovalid = valid_q;
    assign oready = (state_q == StIdle);

endmodule
